d8_mem_arbiter: RTL and testbench

- Shares the 256x8 single-port data memory between two requesters: port A (d8 core load/store unit) and port B (debug/DMA).
- At most one access per cycle; round-robin arbitration; optional lock for atomic read-modify-write sequences.
- Sits between the requesters and the data memory; drives its addr/din/w and samples its combinational dout.

---
 rtl/d8_pkg.sv | 30 +++
 rtl/d8_mem_arbiter_if.sv | 55 +++++
 rtl/d8_rr_arb2.sv | 21 ++
 rtl/d8_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_d8_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/d8_pkg.sv
// Shared definitions for the d8 data-memory arbiter: owner encoding, port indices, widths.
// Latency: none (types and constants only).
// Backpressure: none.
package d8_pkg;

  // Default address/data widths of the d8 data memory.
  localparam int D8_AW = 8;
  localparam int D8_DW = 8;

  // Requester indices into the grant / eligible vectors.
  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // Round-robin "last served" encoding; matches the port index.
  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  // Lock owner state.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  // Counter width able to hold values 0..timeout inclusive.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/d8_mem_arbiter_if.sv
// Requester A/B handshake and data-memory bus of the d8 arbiter.
// Latency: none (wiring only).
// Backpressure: requesters hold X_req and its fields until X_ack pulses.
interface d8_mem_arbiter_if
  import d8_pkg::*;
#(
  parameter int AW = D8_AW,
  parameter int DW = D8_DW
);

  // Port A: d8 core load/store unit
  logic          a_req;
  logic          a_we;
  logic          a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  // Port B: debug / DMA
  logic          b_req;
  logic          b_we;
  logic          b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  // Single-port data memory; mem_dout is combinational from mem_addr
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_w;
  logic [DW-1:0] mem_dout;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_ack, b_rdata,
    output mem_addr, mem_din, mem_w,
    input  mem_dout
  );

  // Requester + memory side
  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  mem_addr, mem_din, mem_w,
    output mem_dout
  );

endinterface

// File: rtl/d8_rr_arb2.sv
// Two-way round-robin picker: one-hot grant among eligible requesters, favouring the one not served last.
// Latency: combinational.
// Backpressure: none; an ineligible requester simply gets no grant bit.
module d8_rr_arb2 (
  input  logic [1:0] eligible_i,
  input  logic       last_i,     // index of the requester served most recently
  output logic [1:0] grant_o
);

  // A lone eligible requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_o = 2'b00;
    case (eligible_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/d8_mem_arbiter.sv
// Shares the 256x8 single-port d8 data memory between port A and port B, round-robin with an RMW lock.
// Latency: grant in cycle t drives the memory combinationally; X_ack/X_rdata appear in cycle t+1.
// Backpressure: a requester waits with X_req high until acked; the ack cycle masks that port so the other may go.
module d8_mem_arbiter
  import d8_pkg::*;
#(
  parameter int AW           = D8_AW,
  parameter int DW           = D8_DW,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,   // asynchronous, active low
  d8_mem_arbiter_if.slave bus,
  output logic            lock_err
);

  localparam int            CW      = cnt_width(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT);

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_last_q, rr_last_d;
  logic          a_ack_q, b_ack_q;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic [1:0]    elig;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic          win_we;
  logic          win_lock;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          owner_gnt;
  logic          timeout;

  // A port competes only while requesting, outside its own ack cycle, and when no one else holds the lock.
  always_comb begin
    elig         = 2'b00;
    elig[PORT_A] = bus.a_req & ~a_ack_q & ((owner_q == NONE) | (owner_q == OWN_A));
    elig[PORT_B] = bus.b_req & ~b_ack_q & ((owner_q == NONE) | (owner_q == OWN_B));
  end

  d8_rr_arb2 u_rr (
    .eligible_i (elig),
    .last_i     (rr_last_q),
    .grant_o    (pick)
  );

  // Reset kills the grant so the memory sees no strobe while reset is held.
  assign gnt = pick & {2{sys_rst}};

  // Steer the winning port onto the memory bus; idle bus is all zeros.
  always_comb begin
    win_we    = 1'b0;
    win_lock  = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (gnt[PORT_A]) begin
      win_we    = bus.a_we;
      win_lock  = bus.a_lock;
      win_addr  = bus.a_addr;
      win_wdata = bus.a_wdata;
    end else if (gnt[PORT_B]) begin
      win_we    = bus.b_we;
      win_lock  = bus.b_lock;
      win_addr  = bus.b_addr;
      win_wdata = bus.b_wdata;
    end
  end

  assign bus.mem_addr = win_addr;
  assign bus.mem_din  = win_wdata;
  assign bus.mem_w    = win_we;

  // Lock owner FSM with idle timeout; a grant to the owner always beats a timeout in the same cycle.
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout   = 1'b0;
    owner_gnt = ((owner_q == OWN_A) & gnt[PORT_A]) | ((owner_q == OWN_B) & gnt[PORT_B]);
    case (owner_q)
      NONE: begin
        cnt_d = '0;
        if (gnt[PORT_A] && bus.a_lock) begin
          owner_d = OWN_A;
        end else if (gnt[PORT_B] && bus.b_lock) begin
          owner_d = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        if (owner_gnt) begin
          cnt_d = '0;
          // An owner access without lock is the unlocking access.
          if (!win_lock) begin
            owner_d = NONE;
          end
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (cnt_d == CNT_MAX) begin
            owner_d = NONE;
            timeout = 1'b1;
          end
        end
      end
      default: begin
        owner_d = NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // lock_err marks the cycle whose closing edge force-releases the lock.
  assign lock_err = timeout;

  // Capture read data for the winner and remember who was served.
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    rr_last_d = rr_last_q;
    if (gnt[PORT_A]) begin
      rr_last_d = RR_A;
      if (!bus.a_we) begin
        a_rdata_d = bus.mem_dout;
      end
    end
    if (gnt[PORT_B]) begin
      rr_last_d = RR_B;
      if (!bus.b_we) begin
        b_rdata_d = bus.mem_dout;
      end
    end
  end

  // State registers; an access in flight at reset is dropped without an ack.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      owner_q   <= NONE;
      cnt_q     <= '0;
      rr_last_q <= RR_B;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      a_ack_q   <= gnt[PORT_A];
      b_ack_q   <= gnt[PORT_B];
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign bus.a_ack   = a_ack_q;
  assign bus.b_ack   = b_ack_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_d8_mem_arbiter.sv
// Directed bench for d8_mem_arbiter with a behavioural 256x8 memory and per-port read-data scoreboards.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
// Expected read data is queued when an access is presented and popped on each ack.
module tb_d8_mem_arbiter;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic lock_err;

  int n_tests = 0;
  int n_fail  = 0;

  d8_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  d8_mem_arbiter #(.AW(8), .DW(8), .LOCK_TIMEOUT(16)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .lock_err (lock_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Memory contents at time zero; 0x20 holds 0x20 so the RMW increment is easy to see.
  function automatic logic [7:0] pat(input int i);
    logic [7:0] v;
    v = 8'(i);
    return (i == 32) ? 8'h20 : (v ^ 8'h3C);
  endfunction

  // Behavioural data memory: combinational read, write on the rising edge.
  logic [7:0] mem [256];
  assign bus.mem_dout = mem[bus.mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    forever begin
      @(posedge sys_clk);
      if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_din;
    end
  end

  // Reference model used to predict read data.
  logic [7:0] ref_mem [256];
  logic [7:0] last_exp [2];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] e_a, e_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue the read data port p must return when this access completes.
  task automatic push(input int p, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    logic [7:0] e;
    if (we) begin
      e = last_exp[p];
      ref_mem[addr] = wd;
    end else begin
      e = ref_mem[addr];
    end
    last_exp[p] = e;
    if (p == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [7:0] addr, input logic [7:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge sys_clk);
  endtask

  // Scoreboard: every ack must match the oldest queued expectation for that port.
  always @(negedge sys_clk) begin
    if (bus.a_ack === 1'b1) begin
      n_tests++;
      assert (qa.size() > 0) else begin
        n_fail++;
        $error("FAIL a_ack_unexpected observed=ack expected=no_ack");
      end
      if (qa.size() > 0) begin
        e_a = qa.pop_front();
        check("a_rdata", 32'(bus.a_rdata), 32'(e_a));
      end
    end
    if (bus.b_ack === 1'b1) begin
      n_tests++;
      assert (qb.size() > 0) else begin
        n_fail++;
        $error("FAIL b_ack_unexpected observed=ack expected=no_ack");
      end
      if (qb.size() > 0) begin
        e_b = qb.pop_front();
        check("b_rdata", 32'(bus.b_rdata), 32'(e_b));
      end
    end
  end

  initial begin
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    last_exp[0] = 8'h00;
    last_exp[1] = 8'h00;
    #2 sys_rst = 1'b0;

    // ---- reset state
    at_neg();
    check("rst_a_ack",    32'(bus.a_ack),    32'h0);
    check("rst_b_ack",    32'(bus.b_ack),    32'h0);
    check("rst_a_rdata",  32'(bus.a_rdata),  32'h0);
    check("rst_b_rdata",  32'(bus.b_rdata),  32'h0);
    check("rst_lock_err", 32'(lock_err),     32'h0);
    check("rst_mem_w",    32'(bus.mem_w),    32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);

    // ---- single write then read on A
    tick();
    sys_rst = 1'b1;
    set_a(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A);
    push(0, 1'b1, 8'h10, 8'h5A);
    at_neg();
    check("wr_mem_w",    32'(bus.mem_w),    32'h1);
    check("wr_mem_addr", 32'(bus.mem_addr), 32'h10);
    check("wr_mem_din",  32'(bus.mem_din),  32'h5A);
    check("wr_no_ack_t", 32'(bus.a_ack),    32'h0);
    tick();
    set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    push(0, 1'b0, 8'h10, 8'h00);
    at_neg();
    check("wr_ack_t1",      32'(bus.a_ack),    32'h1);
    check("ackcyc_no_gnt",  32'(bus.mem_addr), 32'h0);
    check("ackcyc_mem_w",   32'(bus.mem_w),    32'h0);
    tick();
    at_neg();
    check("rd_mem_addr", 32'(bus.mem_addr), 32'h10);
    check("rd_mem_w",    32'(bus.mem_w),    32'h0);
    tick();
    bus.a_req = 1'b0;
    at_neg();
    check("rd_ack",   32'(bus.a_ack),   32'h1);
    check("rd_rdata", 32'(bus.a_rdata), 32'h5A);
    tick();
    at_neg();
    check("rd_ack_pulse", 32'(bus.a_ack), 32'h0);

    // ---- reset again so arbitration starts from its reset priority
    #2 sys_rst = 1'b0;
    #1;
    check("rst2_a_rdata", 32'(bus.a_rdata), 32'h0);
    tick();
    sys_rst = 1'b1;
    last_exp[0] = 8'h00;
    last_exp[1] = 8'h00;

    // ---- contention: A first, then strict alternation
    set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, 8'h10, 8'h00);
      push(1, 1'b0, 8'h30, 8'h00);
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      if (k == 5) bus.a_req = 1'b0;
      at_neg();
      check("cont_addr", 32'(bus.mem_addr), (k % 2 == 0) ? 32'h10 : 32'h30);
      check("cont_w",    32'(bus.mem_w),    32'h0);
    end
    tick();
    bus.b_req = 1'b0;
    at_neg();
    check("cont_b_last_ack", 32'(bus.b_ack), 32'h1);

    // ---- atomic RMW on B while A keeps requesting
    tick();
    set_b(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
    push(1, 1'b0, 8'h20, 8'h00);
    at_neg();
    check("rmw_rd_addr", 32'(bus.mem_addr), 32'h20);
    check("rmw_rd_w",    32'(bus.mem_w),    32'h0);
    tick();
    set_b(1'b1, 1'b1, 1'b0, 8'h20, 8'h21);
    push(1, 1'b1, 8'h20, 8'h21);
    set_a(1'b1, 1'b1, 1'b0, 8'h40, 8'h77);
    push(0, 1'b1, 8'h40, 8'h77);
    at_neg();
    check("rmw_b_ack1",    32'(bus.b_ack),    32'h1);
    check("rmw_a_blocked", 32'(bus.mem_addr), 32'h0);
    check("rmw_a_blk_w",   32'(bus.mem_w),    32'h0);
    tick();
    at_neg();
    check("rmw_wr_addr", 32'(bus.mem_addr), 32'h20);
    check("rmw_wr_w",    32'(bus.mem_w),    32'h1);
    check("rmw_wr_din",  32'(bus.mem_din),  32'h21);
    tick();
    bus.b_req = 1'b0;
    at_neg();
    check("rmw_b_ack2",       32'(bus.b_ack),    32'h1);
    check("rmw_a_after_addr", 32'(bus.mem_addr), 32'h40);
    check("rmw_a_after_w",    32'(bus.mem_w),    32'h1);
    tick();
    bus.a_req = 1'b0;
    at_neg();
    check("rmw_a_ack", 32'(bus.a_ack), 32'h1);
    check("rmw_mem20", 32'(mem[32]),   32'h21);

    // ---- lock timeout: A locks then goes silent, B waits
    tick();
    set_a(1'b1, 1'b0, 1'b1, 8'h50, 8'h00);
    push(0, 1'b0, 8'h50, 8'h00);
    at_neg();
    check("to_lock_addr", 32'(bus.mem_addr), 32'h50);
    tick();
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b1, 1'b0, 1'b0, 8'h60, 8'h00);
    push(1, 1'b0, 8'h60, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) tick();
      at_neg();
      check("to_lock_err", 32'(lock_err),     (i == 16) ? 32'h1 : 32'h0);
      check("to_b_wait",   32'(bus.mem_addr), 32'h0);
    end
    tick();
    at_neg();
    check("to_err_pulse", 32'(lock_err),     32'h0);
    check("to_b_gnt",     32'(bus.mem_addr), 32'h60);
    tick();
    bus.b_req = 1'b0;
    at_neg();
    check("to_b_ack", 32'(bus.b_ack), 32'h1);

    // ---- asynchronous reset in the middle of an A write
    tick();
    set_a(1'b1, 1'b1, 1'b0, 8'h70, 8'hFF);
    at_neg();
    check("ar_pre_w", 32'(bus.mem_w), 32'h1);
    #2 sys_rst = 1'b0;
    #1;
    check("ar_mem_w",    32'(bus.mem_w),    32'h0);
    check("ar_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("ar_mem_din",  32'(bus.mem_din),  32'h0);
    check("ar_a_rdata",  32'(bus.a_rdata),  32'h0);
    check("ar_b_rdata",  32'(bus.b_rdata),  32'h0);
    check("ar_acks",     32'({bus.a_ack, bus.b_ack}), 32'h0);
    check("ar_lock_err", 32'(lock_err),     32'h0);
    tick();
    bus.a_req = 1'b0;
    at_neg();
    check("ar_mem70", 32'(mem[112]),  32'(pat(112)));
    check("ar_no_ack", 32'(bus.a_ack), 32'h0);
    tick();
    sys_rst = 1'b1;
    last_exp[0] = 8'h00;
    last_exp[1] = 8'h00;
    at_neg();
    check("ar_no_ack_after", 32'(bus.a_ack), 32'h0);

    // ---- idle bus
    for (int i = 0; i < 10; i++) begin
      tick();
      at_neg();
      check("idle_mem_w",    32'(bus.mem_w),    32'h0);
      check("idle_mem_addr", 32'(bus.mem_addr), 32'h0);
      check("idle_acks",     32'({bus.a_ack, bus.b_ack}), 32'h0);
      check("idle_lock_err", 32'(lock_err),     32'h0);
    end

    // ---- every queued access must have been acknowledged
    check("a_queue_drained", 32'(qa.size()), 32'h0);
    check("b_queue_drained", 32'(qb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
